rss0: RTL and testbench
=======================

// Module: rss0
// PURPOSE
//  Recursive-running-sum (CIC) decimation filter for the PDM microphone path.
//  Takes one signed sample per enabled clock (a PDM bit arrives as 0/1).
//  Produces a 3rd-order CIC (R=10, M=1) decimated output, held between updates.
//  Sits between the PDM capture logic and the downstream PCM/L1 processing.
// PARAMETERS
//  N      16  input/output sample width (two's complement)
//  R      10  decimation ratio (>=2)
//  W      26  internal accumulator width = N + ceil(3*log2(R))
//  SHIFT  0   output LSB select: data_out = comb3[SHIFT+N-1:SHIFT]
// PORTS
//  clk       in   1  clock; all state updates on rising edge
//  rst       in   1  reset, asynchronous, active-high
//  we        in   1  sample valid; data_in is consumed on edges where we=1
//  Ctrl      in   1  filter run enable; 0 freezes all state
//  data_in   in   N  input sample, signed (PDM: 16'd0 or 16'd1)
//  data_out  out  N  decimated filter output, signed, registered
// BEHAVIOUR
//  - Reset values: sum1, sum2, sum3, decimation count, comb delays, data_out = 0.
//  - en = we & Ctrl; when en=0 every register holds its value.
//  - Internal signed W-bit register named sum1 (first integrator) stays
//    hierarchically visible; benches probe it.
//  - Integrators on each en edge, using pre-edge values, all mod 2^W wrap:
//    sum1 <= sum1 + sext(data_in)
//    sum2 <= sum2 + sum1
//    sum3 <= sum3 + sum2
//  - Decimation counter cnt: 0..R-1, +1 per en edge, wraps to 0 after R-1.
//  - Decimation strobe = en & (cnt==R-1), i.e. every R-th enabled sample.
//  - On the strobe edge, combs are evaluated from the pre-edge sum3:
//    c1 = sum3 - d1
//    c2 = c1 - d2
//    c3 = c2 - d3
//    then d1<=sum3, d2<=c1, d3<=c2, data_out<=c3[SHIFT+N-1:SHIFT].
//  - Comb arithmetic is W-bit modular; the wrap cancels, so the result is exact.
//  - data_out changes only on strobe edges and holds otherwise.
//  - DC gain is R^3 = 1000; constant input x gives steady output 1000*x
//    from the 4th decimated output onward (SHIFT=0).
//  - Reset mid-operation: all state clears at once; the next en edge is sample 1.
//  - Ctrl or we deasserted mid-frame: the frame pauses and resumes with no loss.
// TESTING
//  1 Reset, we=1, Ctrl=1, data_in=1 constant.
//    -> sum1 = k after k edges.
//    -> data_out = 84, 717, 999, 1000, 1000... after edges 10, 20, 30, 40, 50.
//  2 data_in=0 constant after reset -> sum1 = 0 and data_out = 0 throughout.
//  3 Alternating 1,0,1,0... -> data_out settles to 500 by the 4th output.
//  4 data_in = -1 (16'hFFFF) constant -> outputs -84, -717, -999, then -1000.
//  5 Run 15 edges with data_in=1, drop we (or Ctrl) for 7 cycles, then resume.
//    -> outputs identical to scenario 1 counted in enabled edges.
//    -> data_out and sum1 frozen while disabled.
//  6 Assert rst asynchronously mid-frame (between edges).
//    -> data_out and sum1 = 0 immediately.
//    -> restarting with data_in=1 reproduces scenario 1 exactly.

Source files
------------

// File: rtl/rss0.sv
// Third-order CIC decimator (M=1) for the PDM microphone path.
// Integrators run on every enabled sample; combs run once per R enabled samples.
module rss0 #(
  parameter int N     = 16,
  parameter int R     = 10,
  parameter int W     = 26,
  parameter int SHIFT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                Ctrl,
  input  logic signed [N-1:0] data_in,
  output logic signed [N-1:0] data_out
);

  localparam int CW = (R > 1) ? $clog2(R) : 1;

  logic                en;
  logic                strobe;
  logic [CW-1:0]       cnt;
  logic signed [W-1:0] sum1, sum2, sum3;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] c1, c2, c3;
  logic signed [W-1:0] din_ext;

  assign en      = we & Ctrl;
  assign strobe  = en && (cnt == CW'(R - 1));
  assign din_ext = {{(W-N){data_in[N-1]}}, data_in};

  // Wrap-around in the integrators is undone exactly by the modular combs.
  always_comb begin
    c1 = sum3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum1     <= '0;
      sum2     <= '0;
      sum3     <= '0;
      cnt      <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      data_out <= '0;
    end else if (en) begin
      sum1 <= sum1 + din_ext;
      sum2 <= sum2 + sum1;
      sum3 <= sum3 + sum2;
      cnt  <= strobe ? '0 : cnt + 1'b1;
      if (strobe) begin
        d1       <= sum3;
        d2       <= c1;
        d3       <= c2;
        data_out <= N'(c3 >>> SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_rss0.sv
// Directed bench for rss0: constant, alternating and negative inputs,
// enable pauses, and asynchronous reset in the middle of a frame.
module tb_rss0;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               we = 1'b0;
  logic               Ctrl = 1'b0;
  logic signed [15:0] data_in = '0;
  logic signed [15:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  rss0 dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .Ctrl     (Ctrl),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    we = 1'b1; Ctrl = 1'b1; data_in = 16'sd1;
    run(2);
    check("reset_data_out", data_out, 0);
    check("reset_sum1", dut.sum1, 0);

    // Scenario 1: constant 1
    do_reset();
    run(5);
    check("s1_sum1_5", dut.sum1, 5);
    check("s1_out_pre", data_out, 0);
    run(4);
    check("s1_sum1_9", dut.sum1, 9);
    check("s1_out_edge9", data_out, 0);
    run(1);
    check("s1_out_10", data_out, 84);
    check("s1_sum1_10", dut.sum1, 10);
    run(1);
    check("s1_hold_11", data_out, 84);
    run(9);
    check("s1_out_20", data_out, 717);
    run(10);
    check("s1_out_30", data_out, 999);
    run(10);
    check("s1_out_40", data_out, 1000);
    run(10);
    check("s1_out_50", data_out, 1000);
    check("s1_sum1_50", dut.sum1, 50);

    // Scenario 2: constant 0
    data_in = 16'sd0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      run(10);
      check("s2_out", data_out, 0);
      check("s2_sum1", dut.sum1, 0);
    end

    // Scenario 3: alternating 1,0,1,0...
    do_reset();
    for (int k = 1; k <= 50; k++) begin
      data_in = (k % 2 == 1) ? 16'sd1 : 16'sd0;
      run(1);
      if (k == 40) check("s3_out_40", data_out, 500);
      if (k == 50) check("s3_out_50", data_out, 500);
    end
    check("s3_sum1_50", dut.sum1, 25);

    // Scenario 4: constant -1
    data_in = -16'sd1;
    do_reset();
    run(10);
    check("s4_out_10", data_out, -84);
    check("s4_sum1_10", dut.sum1, -10);
    run(10);
    check("s4_out_20", data_out, -717);
    run(10);
    check("s4_out_30", data_out, -999);
    run(10);
    check("s4_out_40", data_out, -1000);
    run(10);
    check("s4_out_50", data_out, -1000);

    // Scenario 5: pause mid-frame via we, then via Ctrl
    data_in = 16'sd1;
    do_reset();
    run(15);
    check("s5_sum1_15", dut.sum1, 15);
    check("s5_out_15", data_out, 84);
    we = 1'b0;
    run(4);
    check("s5_we_hold_sum1", dut.sum1, 15);
    check("s5_we_hold_out", data_out, 84);
    we = 1'b1; Ctrl = 1'b0;
    run(3);
    check("s5_ctrl_hold_sum1", dut.sum1, 15);
    check("s5_ctrl_hold_out", data_out, 84);
    Ctrl = 1'b1;
    run(4);
    check("s5_out_19", data_out, 84);
    run(1);
    check("s5_out_20", data_out, 717);
    check("s5_sum1_20", dut.sum1, 20);
    run(10);
    check("s5_out_30", data_out, 999);
    run(10);
    check("s5_out_40", data_out, 1000);

    // Scenario 6: asynchronous reset between edges
    do_reset();
    run(23);
    check("s6_out_pre", data_out, 717);
    check("s6_sum1_pre", dut.sum1, 23);
    #2 rst = 1'b1;
    #1;
    check("s6_async_out", data_out, 0);
    check("s6_async_sum1", dut.sum1, 0);
    @(negedge clk);
    rst = 1'b0;
    run(9);
    check("s6_sum1_9", dut.sum1, 9);
    check("s6_out_9", data_out, 0);
    run(1);
    check("s6_out_10", data_out, 84);
    run(10);
    check("s6_out_20", data_out, 717);
    run(10);
    check("s6_out_30", data_out, 999);
    run(10);
    check("s6_out_40", data_out, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
